// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall and taken-branch flush sequencing.
// Define HAZARD_STATS_EN to add saturating stall_count/flush_count outputs.
module hazard_control_unit #(
    parameter int         CNT_W    = 16,
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       mem_take_branch,
    output logic       pc_enable,
    output logic       if_id_enable,
    output logic       id_ex_enable,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       ex_mem_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        FLUSH
    } state_e;

    state_e state_q, state_d;
    logic   load_use;
    logic   stall_evt;

    always_comb begin
        load_use = ex_mem_read && (ex_rd != ZERO_REG) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

    // NOTE: every output and state_d gets a default first, so no path through
    // the branches below can leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = RUN;
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        id_ex_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        stall_evt    = 1'b0;

        // Reset forces the quiet outputs regardless of inputs or current state.
        if (!reset) begin
            if (mem_take_branch) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
                state_d      = FLUSH;
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (load_use) begin
                            pc_enable    = 1'b0;
                            if_id_enable = 1'b0;
                            id_ex_bubble = 1'b1;
                            stall_evt    = 1'b1;
                            state_d      = LOAD_STALL;
                        end
                    end
                    LOAD_STALL: state_d = RUN;
                    FLUSH:      state_d = RUN;
                    default:    state_d = RUN;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; reset is synchronous, inside the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_evt && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (ex_mem_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-002 SHALL have parameter ZERO_REG, default 5'd31: register index that never creates a hazard.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each: source registers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each: the ID instruction reads that source.
REQ-007 SHALL have port ex_rd  input  5: destination held in ID/EX (rd_out).
REQ-008 SHALL have port ex_mem_read  input  1: ID/EX mem_mem_read_out.
REQ-009 SHALL have port mem_take_branch  input  1: branch resolved taken in MEM.
REQ-010 SHALL have ports pc_enable, if_id_enable, id_ex_enable  output  1 each: pipeline write enables.
REQ-011 SHALL have ports if_id_flush, id_ex_bubble, ex_mem_flush  output  1 each: zero the control fields of that pipeline register on the next edge.
REQ-012 SHALL have ports stall_count, flush_count  output  CNT_W each: present only with HAZARD_STATS_EN.

Function
REQ-013 SHALL implement FSM states RUN, LOAD_STALL, FLUSH; outputs are combinational from state and inputs, with no added latency.
REQ-014 load_use SHALL be ex_mem_read && ex_rd!=ZERO_REG && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
REQ-015 In RUN with load_use and !mem_take_branch: pc_enable=0, if_id_enable=0, id_ex_bubble=1, id_ex_enable=1; next state LOAD_STALL.
REQ-016 LOAD_STALL SHALL last exactly one cycle: load_use is masked, all enables are 1, bubble and flushes are 0, and the next state is RUN unless mem_take_branch.
REQ-017 When mem_take_branch=1 in any state: if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, all enables=1, load_use ignored; next state FLUSH.
REQ-018 Branch SHALL take priority over load-use in the same cycle; the pending stall is discarded.
REQ-019 FLUSH SHALL last one cycle with load_use masked and all flushes 0; next state RUN, or FLUSH again if mem_take_branch=1.
REQ-020 In RUN with neither condition: all enables 1, all flush/bubble 0; state stays RUN.
REQ-021 Counters SHALL saturate at all-ones and never wrap.

Reset
REQ-022 When reset=1 at an edge, state SHALL become RUN and counters SHALL become 0.
REQ-023 While reset=1: enables=1, flush/bubble=0, and all inputs are ignored, including mid-stall and mid-flush.
REQ-024 The first cycle after reset deasserts SHALL evaluate from RUN.

Configuration
REQ-025 Macro HAZARD_STATS_EN, when defined, SHALL add stall_count (+1 per cycle with id_ex_bubble from load_use) and flush_count (+1 per cycle with ex_mem_flush).
REQ-026 Without HAZARD_STATS_EN, the counters and their ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> pc_enable=0, if_id_enable=0, id_ex_bubble=1 for exactly 1 cycle, then RUN.
REQ-028 Same as REQ-027 but ex_rd=31 -> no stall; all enables stay 1.
REQ-029 load_use and mem_take_branch both 1 in one cycle -> all three flushes asserted, enables 1, state FLUSH, stall_count unchanged.
REQ-030 mem_take_branch held for 3 cycles -> flushes asserted each cycle, flush_count=3, never stalls.
REQ-031 reset=1 asserted in LOAD_STALL -> next cycle RUN, enables 1, counters 0.
REQ-032 Preload stall_count to all-ones (CNT_W=4, 15 stalls) then 1 more stall -> stall_count stays 15.
